uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- 8N1 UART receiver; the serial input stage that sits directly upstream of the project core and feeds it bytes.
- Takes one raw pin from ui_in, synchronises it, validates the start bit and samples each bit mid-period.
- Presents each received byte on a valid/ready interface backed by a one-byte holding register.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (must be >= 4; 104 gives about 115200 baud at 12 MHz).
- SYNC_STAGES, 2, flops in the input synchroniser (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rx_in  input  1  raw asynchronous serial line (idle high)
- rx_data  output  8  received byte, valid while rx_valid=1
- rx_valid  output  1  holding register full
- rx_ready  input  1  consumer accepts the byte when rx_valid && rx_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit (or parity) bad, byte discarded
- overrun  output  1  one-cycle pulse: byte completed while holding register full, new byte dropped
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. Everything else is synchronous to the rising edge of clk.
- Reset values:
  - Synchroniser flops = 1.
  - FSM = IDLE; baud counter = 0; bit index = 0.
  - shift = 0x00; rx_data = 0x00.
  - rx_valid = 0; frame_err = 0; overrun = 0; busy = 0.
- Reset mid-frame aborts the frame with no output. After reset deasserts, the block waits for a fresh falling edge.
- rxs denotes the synchronised rx_in.
- Baud counter width is $clog2(CLKS_PER_BIT). It is cleared on every state transition.
- FSM states and transitions:
  - IDLE: rxs==0 -> START, counter cleared.
  - START: when counter == CLKS_PER_BIT/2 - 1 (integer division), re-sample rxs.
    - 0 -> DATA.
    - 1 -> IDLE (glitch rejected, no flag).
  - DATA: when counter == CLKS_PER_BIT - 1, shift rxs into the MSB (LSB-first reception) and increment the bit index.
    - After the 8th bit -> STOP (or PARITY if enabled).
  - STOP: when counter == CLKS_PER_BIT - 1, sample rxs, then -> IDLE.
    - rxs==1 and no parity error: deliver.
    - Otherwise: frame_err=1 for one cycle, no delivery.
  - On entering IDLE from STOP, a low rxs in IDLE starts the next frame immediately, so back-to-back frames are supported.
- Delivery, in the cycle STOP completes:
  - Holding register is empty, or is being consumed this same cycle (rx_valid && rx_ready): rx_data <= shift and rx_valid <= 1.
  - Otherwise: overrun=1 for one cycle; rx_data and rx_valid are unchanged.
- Handshake:
  - rx_valid stays high until rx_valid && rx_ready; it clears on the next edge unless a simultaneous delivery reloads it.
  - rx_data is stable while rx_valid=1.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after rx_in falls. This includes SYNC_STAGES = 2; each extra stage adds one cycle.
- A line held low continuously (break condition) gives frame_err once per frame time and never asserts rx_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit long and sampled mid-bit.
  - The sampled parity bit must give even parity over data and parity bit.
  - A mismatch causes a frame_err pulse at stop-bit time and the byte is discarded, even if the stop bit is good.
  - Frame becomes 8E1 and latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; the block is 8N1 only.

Test Plan:
- CLKS_PER_BIT=16; send 0xA5 with rx_ready=1 -> rx_valid pulses for exactly one cycle with rx_data=0xA5, about 154 cycles after the start edge; frame_err=0 and overrun=0.
- Send 0x3C then 0x81 back-to-back with rx_ready=0; then raise rx_ready -> rx_data=0x3C is held; overrun pulses once at the end of 0x81; the next accept returns rx_valid=0.
- 0x55 with stop bit driven 0 -> frame_err pulses once; rx_valid stays 0; the next good frame 0x12 is received correctly.
- 3-cycle low glitch on idle line -> FSM goes START then back to IDLE; no rx_valid, no frame_err; busy falls within CLKS_PER_BIT/2 + 3 cycles.
- Assert rst halfway through the data bits of 0xFF -> all outputs go to reset values immediately; the next frame 0x0F is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted, rx_data=0x07; same byte with parity bit 0 -> frame_err pulse, no rx_valid.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: synchroniser, start-bit qualification, mid-bit sampling,
// one-byte valid/ready holding register. Define UART_RX_PARITY_EN for 8E1 (even parity) frames.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic [CNT_W-1:0]        r_cnt;
    logic [2:0]              r_bit_idx;
    logic [7:0]              r_shift;
    logic                    w_rxs;
    logic                    w_cnt_clr;
    logic                    w_bit_tick;
    logic                    w_stop_tick;
    logic                    w_frame_ok;
    logic                    w_deliver;
    logic                    w_accept;
`ifdef UART_RX_PARITY_EN
    logic                    w_par_tick;
    logic                    r_par_err;
`endif

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '1;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
    end

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_bit_tick  = 1'b0;
        w_stop_tick = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_tick  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_bit_tick = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
`else
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_par_tick  = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_stop_tick = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_frame_ok = w_rxs && !r_par_err;
`else
    assign w_frame_ok = w_rxs;
`endif
    assign w_accept  = rx_valid && rx_ready;
    // A byte may land in the same cycle the consumer empties the holding register
    assign w_deliver = w_stop_tick && w_frame_ok && (!rx_valid || rx_ready);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (w_bit_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {w_rxs, r_shift[7:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_par_err <= 1'b0;
        else if (w_par_tick) r_par_err <= ^{w_rxs, r_shift};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_stop_tick && !w_frame_ok;
            overrun   <= w_stop_tick && w_frame_ok && rx_valid && !rx_ready;
            if (w_deliver) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (w_accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at CLKS_PER_BIT=16; parity scenario under UART_RX_PARITY_EN.
module tb_uart_rx_frontend;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam int LAT   = 2 + HALF + 10 * CPB;
`else
    localparam int NBITS = 10;
    localparam int LAT   = 2 + HALF + 9 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Event monitor: written only here, read by the test tasks as deltas
    int         cyc = 0;
    int         n_vrise = 0;
    int         n_vhigh = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         rise_cyc = 0;
    logic [7:0] last_data = 8'h00;
    logic       prev_valid = 1'b0;
    int         start_cyc = 0;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_err) n_ferr = n_ferr + 1;
        if (overrun)   n_ovr  = n_ovr + 1;
        if (rx_valid)  n_vhigh = n_vhigh + 1;
        if (rx_valid && !prev_valid) begin
            n_vrise   = n_vrise + 1;
            last_data = rx_data;
            rise_cyc  = cyc;
        end
        prev_valid = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is aligned 1 ns after a rising edge; returns aligned the same way after the stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
`else
        bits = {par_flip, stop_bit, d, 1'b0};
`endif
        start_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            rx_in = bits[i];
            idle(CPB);
        end
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
        idle(3);
        n_checks++; if (rx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_checks++; if (overrun !== 1'b0)   begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_single();
        int v0, h0, f0, o0, lat;
        rx_ready = 1'b1;
        v0 = n_vrise; h0 = n_vhigh; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        lat = rise_cyc - start_cyc - 2;
        n_checks++; if (n_vrise - v0 !== 1)  begin n_fail++; $display("FAIL single_count: got %0d want 1", n_vrise - v0); end
        n_checks++; if (last_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", last_data); end
        n_checks++; if (n_vhigh - h0 !== 1)  begin n_fail++; $display("FAIL single_width: got %0d want 1", n_vhigh - h0); end
        n_checks++; if (lat < LAT - 1 || lat > LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
        n_checks++; if (n_ferr - f0 !== 0)   begin n_fail++; $display("FAIL single_ferr: got %0d want 0", n_ferr - f0); end
        n_checks++; if (n_ovr - o0 !== 0)    begin n_fail++; $display("FAIL single_ovr: got %0d want 0", n_ovr - o0); end
    endtask

    task automatic test_back_to_back();
        int v0, f0, o0;
        rx_ready = 1'b0;
        v0 = n_vrise; f0 = n_ferr; o0 = n_ovr;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(4);
        n_checks++; if (n_vrise - v0 !== 1)  begin n_fail++; $display("FAIL b2b_count: got %0d want 1", n_vrise - v0); end
        n_checks++; if (rx_valid !== 1'b1)   begin n_fail++; $display("FAIL b2b_held_valid: got %b want 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h3C)   begin n_fail++; $display("FAIL b2b_held_data: got %h want 3c", rx_data); end
        n_checks++; if (n_ovr - o0 !== 1)    begin n_fail++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr - o0); end
        n_checks++; if (n_ferr - f0 !== 0)   begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", n_ferr - f0); end
        rx_ready = 1'b1;
        idle(1);
        n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL b2b_accept: got %b want 0", rx_valid); end
        idle(4);
    endtask

    task automatic test_frame_err();
        int v0, f0;
        v0 = n_vrise; f0 = n_ferr;
        send_frame(8'h55, 1'b0, 1'b0);
        idle(2 * CPB);
        n_checks++; if (n_ferr - f0 !== 1)   begin n_fail++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - f0); end
        n_checks++; if (n_vrise - v0 !== 0)  begin n_fail++; $display("FAIL ferr_novalid: got %0d want 0", n_vrise - v0); end
        v0 = n_vrise; f0 = n_ferr;
        send_frame(8'h12, 1'b1, 1'b0);
        idle(4);
        n_checks++; if (n_vrise - v0 !== 1)  begin n_fail++; $display("FAIL ferr_next_count: got %0d want 1", n_vrise - v0); end
        n_checks++; if (last_data !== 8'h12) begin n_fail++; $display("FAIL ferr_next_data: got %h want 12", last_data); end
        n_checks++; if (n_ferr - f0 !== 0)   begin n_fail++; $display("FAIL ferr_next_clean: got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_glitch();
        int v0, f0, fall_at;
        logic saw_high;
        v0 = n_vrise; f0 = n_ferr; fall_at = -1; saw_high = 1'b0;
        rx_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) saw_high = 1'b1;
            if (saw_high && !busy && fall_at < 0) fall_at = i;
            if (i == 3) rx_in = 1'b1;
        end
        idle(2);
        n_checks++; if (saw_high !== 1'b1)   begin n_fail++; $display("FAIL glitch_busy_rise: got %b want 1", saw_high); end
        n_checks++; if (fall_at < 0 || fall_at - 1 > HALF + 3) begin n_fail++; $display("FAIL glitch_busy_fall: got %0d want <= %0d", fall_at - 1, HALF + 3); end
        n_checks++; if (n_vrise - v0 !== 0)  begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", n_vrise - v0); end
        n_checks++; if (n_ferr - f0 !== 0)   begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - f0); end
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        rx_in = 1'b0;
        idle(CPB);
        rx_in = 1'b1;
        idle(4 * CPB);
        n_checks++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++; if (rx_data !== 8'h00)   begin n_fail++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
        idle(2);
        rst = 1'b0;
        v0 = n_vrise; f0 = n_ferr;
        idle(8 * CPB);
        n_checks++; if (n_vrise - v0 !== 0 || n_ferr - f0 !== 0) begin n_fail++; $display("FAIL rstmid_abort: got %0d/%0d want 0/0", n_vrise - v0, n_ferr - f0); end
        v0 = n_vrise;
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(4);
        n_checks++; if (n_vrise - v0 !== 1)  begin n_fail++; $display("FAIL rstmid_next_count: got %0d want 1", n_vrise - v0); end
        n_checks++; if (last_data !== 8'h0F) begin n_fail++; $display("FAIL rstmid_next_data: got %h want 0f", last_data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0, f0;
        v0 = n_vrise; f0 = n_ferr;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(4);
        n_checks++; if (n_vrise - v0 !== 1)  begin n_fail++; $display("FAIL par_good_count: got %0d want 1", n_vrise - v0); end
        n_checks++; if (last_data !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h want 07", last_data); end
        n_checks++; if (n_ferr - f0 !== 0)   begin n_fail++; $display("FAIL par_good_ferr: got %0d want 0", n_ferr - f0); end
        v0 = n_vrise; f0 = n_ferr;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        n_checks++; if (n_ferr - f0 !== 1)   begin n_fail++; $display("FAIL par_bad_ferr: got %0d want 1", n_ferr - f0); end
        n_checks++; if (n_vrise - v0 !== 0)  begin n_fail++; $display("FAIL par_bad_valid: got %0d want 0", n_vrise - v0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
